fifo_rd_ptr_ctrl: RTL and testbench

Read-side pointer controller for the dual-clock FIFO, running entirely in the read clock domain. It performs the following functions:
- synchronises the write pointer's Gray code;
- converts it to binary;
- maintains the binary and Gray read pointers;
- sequences reads into the external dual-port RAM;
- generates EMPTY, ALMOST_EMPTY, fill-level and underflow status.

---
 rtl/fifo_rd_ptr_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_rd_ptr_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for a dual-clock FIFO (read clock domain only).
// Latency: RD_FIRE_o is combinational; RD_VALID_o follows one cycle later; a write is visible SYNC_STAGES+1 edges after it.
// Backpressure: no read fires while EMPTY_o is set; such a request raises UNDERFLOW_o for one cycle and changes nothing else.
module fifo_rd_ptr_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic              CLK_i,
  input  logic              RST_N_i,
  input  logic [ADDR_W:0]   WPTR_GRAY_i,
  input  logic              RD_EN_i,
  output logic              RD_FIRE_o,
  output logic [ADDR_W-1:0] RADDR_o,
  output logic              RD_VALID_o,
  output logic [ADDR_W:0]   RPTR_GRAY_o,
  output logic              EMPTY_o,
  output logic              ALMOST_EMPTY_o,
  output logic [ADDR_W:0]   COUNT_o,
  output logic              UNDERFLOW_o
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);

  logic [PW-1:0] r_wsync [SYNC_STAGES];
  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rgray;
  logic          r_empty;
  logic          r_almost_empty;
  logic [PW-1:0] r_count;
  logic          r_rd_valid;
  logic          r_underflow;

  logic [PW-1:0] w_wsync;
  logic [PW-1:0] w_wbin;
  logic          w_fire;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_cnt_next;

  // Plain flop chain for the asynchronous write pointer; nothing may sit between stages.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_wsync[i] <= '0;
    end else begin
      r_wsync[0] <= WPTR_GRAY_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_wsync[i] <= r_wsync[i-1];
    end
  end

  assign w_wsync = r_wsync[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits from i upward.
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < PW; i++) w_wbin[i] = ^(w_wsync >> i);
  end

  assign w_fire       = RD_EN_i & ~r_empty;
  assign w_rbin_next  = r_rbin + PW'(w_fire);
  assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
  assign w_cnt_next   = w_wbin - w_rbin_next;

  // Read pointer in binary and Gray; both advance only on an accepted read.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_rbin  <= '0;
      r_rgray <= '0;
    end else begin
      r_rbin  <= w_rbin_next;
      r_rgray <= w_rgray_next;
    end
  end

  // Status uses the post-read pointer so the last read raises empty on its own edge.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_count        <= '0;
    end else begin
      r_empty        <= (w_rgray_next == w_wsync);
      r_almost_empty <= (w_cnt_next <= AE_LVL);
      r_count        <= w_cnt_next;
    end
  end

  // Data-valid follows the RAM read strobe; underflow flags a request refused while empty.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      r_rd_valid  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_valid  <= w_fire;
      r_underflow <= RD_EN_i & r_empty;
    end
  end

  assign RD_FIRE_o      = w_fire;
  assign RADDR_o        = r_rbin[ADDR_W-1:0];
  assign RD_VALID_o     = r_rd_valid;
  assign RPTR_GRAY_o    = r_rgray;
  assign EMPTY_o        = r_empty;
  assign ALMOST_EMPTY_o = r_almost_empty;
  assign COUNT_o        = r_count;
  assign UNDERFLOW_o    = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Bench for fifo_rd_ptr_ctrl: directed vectors with a read-address scoreboard.
// Stimulus pushes the expected RAM address of each read; a monitor pops it when RD_VALID_o shows up.
// Inputs change 2 ns after the rising edge; outputs are sampled 2-4 ns after it or on the falling edge.
module tb_fifo_rd_ptr_ctrl;

  localparam int ADDR_W = 4;
  localparam int PW     = ADDR_W + 1;

  logic              CLK_i;
  logic              RST_N_i;
  logic [PW-1:0]     WPTR_GRAY_i;
  logic              RD_EN_i;
  logic              RD_FIRE_o;
  logic [ADDR_W-1:0] RADDR_o;
  logic              RD_VALID_o;
  logic [PW-1:0]     RPTR_GRAY_o;
  logic              EMPTY_o;
  logic              ALMOST_EMPTY_o;
  logic [PW-1:0]     COUNT_o;
  logic              UNDERFLOW_o;

  fifo_rd_ptr_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(2), .AE_LEVEL(2)) dut (
    .CLK_i          (CLK_i),
    .RST_N_i        (RST_N_i),
    .WPTR_GRAY_i    (WPTR_GRAY_i),
    .RD_EN_i        (RD_EN_i),
    .RD_FIRE_o      (RD_FIRE_o),
    .RADDR_o        (RADDR_o),
    .RD_VALID_o     (RD_VALID_o),
    .RPTR_GRAY_o    (RPTR_GRAY_o),
    .EMPTY_o        (EMPTY_o),
    .ALMOST_EMPTY_o (ALMOST_EMPTY_o),
    .COUNT_o        (COUNT_o),
    .UNDERFLOW_o    (UNDERFLOW_o)
  );

  initial begin
    CLK_i = 1'b0;
    forever #5 CLK_i = ~CLK_i;
  end

  int n_total = 0;
  int n_bad   = 0;
  logic [ADDR_W-1:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK_i);
    #2;
  endtask

  task automatic do_reset();
    RST_N_i     = 1'b0;
    WPTR_GRAY_i = '0;
    RD_EN_i     = 1'b0;
    step(2);
    RST_N_i = 1'b1;
  endtask

  // Monitor: RD_VALID_o must follow each fire by one cycle and carry the queued address.
  logic              m_cap  = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  always @(negedge CLK_i) begin
    if (!RST_N_i) begin
      m_cap = 1'b0;
    end else begin
      chk("rd_valid_latency", RD_VALID_o, m_cap);
      if (RD_VALID_o && m_cap) begin
        if (exp_q.size() == 0) chk("scoreboard_underrun", 1, 0);
        else chk("rd_addr", m_addr, exp_q.pop_front());
      end
      m_cap  = RD_FIRE_o;
      m_addr = RADDR_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  logic [PW-1:0]     w_bin;
  logic [ADDR_W-1:0] exp_addr;
  int n_f, n_uf, n_fire, n_writes, rb;

  initial begin
    // ---------------- reset state ----------------
    RST_N_i = 1'b0; WPTR_GRAY_i = '0; RD_EN_i = 1'b0;
    step(3);
    chk("rst_empty", EMPTY_o, 1);
    chk("rst_aempty", ALMOST_EMPTY_o, 1);
    chk("rst_raddr", RADDR_o, 0);
    chk("rst_rgray", RPTR_GRAY_o, 0);
    chk("rst_count", COUNT_o, 0);
    chk("rst_rvalid", RD_VALID_o, 0);
    chk("rst_uflow", UNDERFLOW_o, 0);
    RST_N_i = 1'b1;

    // ---------------- single entry ----------------
    WPTR_GRAY_i = 5'b00001;
    step(2);
    chk("se_empty_edge2", EMPTY_o, 1);
    step(1);
    chk("se_empty_edge3", EMPTY_o, 0);
    chk("se_count_edge3", COUNT_o, 1);
    chk("se_aempty", ALMOST_EMPTY_o, 1);
    RD_EN_i = 1'b1;
    exp_q.push_back(4'd0);
    #1;
    chk("se_fire", RD_FIRE_o, 1);
    chk("se_raddr_fire", RADDR_o, 0);
    step(1);
    RD_EN_i = 1'b0;
    chk("se_raddr", RADDR_o, 1);
    chk("se_rgray", RPTR_GRAY_o, 5'b00001);
    chk("se_empty", EMPTY_o, 1);
    chk("se_count", COUNT_o, 0);
    chk("se_rvalid", RD_VALID_o, 1);
    step(1);
    chk("se_rvalid_drop", RD_VALID_o, 0);

    // ---------------- underflow ----------------
    RD_EN_i = 1'b1;
    #1;
    chk("uf_fire1", RD_FIRE_o, 0);
    step(1);
    chk("uf_pulse1", UNDERFLOW_o, 1);
    chk("uf_raddr1", RADDR_o, 1);
    chk("uf_rgray1", RPTR_GRAY_o, 5'b00001);
    #1;
    chk("uf_fire2", RD_FIRE_o, 0);
    step(1);
    RD_EN_i = 1'b0;
    chk("uf_pulse2", UNDERFLOW_o, 1);
    chk("uf_rvalid", RD_VALID_o, 0);
    step(1);
    chk("uf_clear", UNDERFLOW_o, 0);
    chk("uf_raddr3", RADDR_o, 1);

    // ---------------- full and wrap ----------------
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      w_bin = PW'(k);
      WPTR_GRAY_i = g(w_bin);
      step(1);
    end
    step(2);
    chk("full_wgray", WPTR_GRAY_i, 5'b11000);
    chk("full_count", COUNT_o, 16);
    chk("full_aempty", ALMOST_EMPTY_o, 0);
    chk("full_empty", EMPTY_o, 0);
    for (int k = 0; k < 16; k++) exp_q.push_back(ADDR_W'(k));
    n_f = 0; n_uf = 0;
    RD_EN_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (RD_FIRE_o) n_f++;
      chk("wrap_fire", RD_FIRE_o, (i < 16));
      chk("wrap_raddr_pre", RADDR_o, (i < 16) ? i : 0);
      step(1);
      rb = (i + 1 < 16) ? i + 1 : 16;
      chk("wrap_raddr", RADDR_o, rb % 16);
      chk("wrap_rgray", RPTR_GRAY_o, g(PW'(rb)));
      chk("wrap_count", COUNT_o, 16 - rb);
      chk("wrap_aempty", ALMOST_EMPTY_o, (16 - rb) <= 2);
      chk("wrap_empty", EMPTY_o, (rb == 16));
      chk("wrap_uflow", UNDERFLOW_o, (i >= 16));
      if (UNDERFLOW_o) n_uf++;
    end
    RD_EN_i = 1'b0;
    step(1);
    chk("wrap_uflow_end", UNDERFLOW_o, 0);
    chk("wrap_nfire", n_f, 16);
    chk("wrap_nuflow", n_uf, 4);
    chk("wrap_rgray_final", RPTR_GRAY_o, 5'b11000);

    // ---------------- concurrent traffic ----------------
    w_bin = 5'd16; exp_addr = '0; n_fire = 0; n_writes = 0;
    fork
      begin
        #($urandom_range(1, 7));
        repeat (66) begin
          w_bin = w_bin + 1'b1;
          WPTR_GRAY_i = g(w_bin);
          n_writes++;
          #30;
        end
      end
      begin
        RD_EN_i = 1'b1;
        repeat (200) begin
          #1;
          if (RD_FIRE_o) begin
            exp_q.push_back(exp_addr);
            exp_addr = exp_addr + 1'b1;
            n_fire++;
          end
          chk("cc_fire_after_write", (n_fire <= n_writes), 1);
          chk("cc_empty_at_zero", ((COUNT_o == 0) && !EMPTY_o), 0);
          step(1);
        end
        RD_EN_i = 1'b0;
      end
    join
    step(4);
    chk("cc_nwrites", n_writes, 66);
    chk("cc_fire_balance", n_fire, n_writes - int'(COUNT_o));
    chk("cc_empty_vs_count", EMPTY_o, (COUNT_o == 0));

    // ---------------- async reset mid-read ----------------
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      w_bin = PW'(k);
      WPTR_GRAY_i = g(w_bin);
      step(1);
    end
    step(2);
    chk("ar_count5", COUNT_o, 5);
    RD_EN_i = 1'b1;
    #1;
    chk("ar_fire", RD_FIRE_o, 1);
    step(1);
    chk("ar_rvalid_before", RD_VALID_o, 1);
    #1;
    RST_N_i = 1'b0;
    WPTR_GRAY_i = '0;
    #1;
    chk("ar_empty", EMPTY_o, 1);
    chk("ar_aempty", ALMOST_EMPTY_o, 1);
    chk("ar_raddr", RADDR_o, 0);
    chk("ar_rgray", RPTR_GRAY_o, 0);
    chk("ar_count", COUNT_o, 0);
    chk("ar_rvalid", RD_VALID_o, 0);
    chk("ar_uflow", UNDERFLOW_o, 0);
    chk("ar_fire_in_rst", RD_FIRE_o, 0);
    step(2);
    RST_N_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("ar_post_empty", EMPTY_o, 1);
      chk("ar_post_rvalid", RD_VALID_o, 0);
    end
    RD_EN_i = 1'b0;
    step(3);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
